// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (IF / D) arbiter for the single memory port of the multi-cycle core
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              win_d;
    logic              last_d;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              grant_d;
    logic              addr_phase;

    // D wins when it is alone, or on a tie when IF was granted last.
    always_comb begin
        grant_d = d_req && (!if_req || !last_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            win_d      <= 1'b0;
            last_d     <= 1'b1;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_req || d_req) begin
                        state     <= ST_ACCESS;
                        win_d     <= grant_d;
                        last_d    <= grant_d;
                        lat_addr  <= grant_d ? d_addr : if_addr;
                        lat_wdata <= grant_d ? d_wdata : '0;
                        lat_we    <= grant_d && d_we;
                    end
                end
                ST_ACCESS: begin
                    if (lat_we) begin
                        state <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                        cnt   <= LAT_INIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= ST_RESP;
                        if (win_d) begin
                            d_rdata_q <= mem_rdata;
                        end else begin
                            if_rdata_q <= mem_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address and write data are only presented while the access is in flight.
    always_comb begin
        addr_phase = (state == ST_ACCESS) || (state == ST_WAIT);
        mem_addr   = addr_phase ? lat_addr : '0;
        mem_wdata  = addr_phase ? lat_wdata : '0;
        mem_read   = (state == ST_ACCESS) && !lat_we;
        mem_write  = (state == ST_ACCESS) && lat_we;
        if_ready   = (state == ST_RESP) && !win_d;
        d_ready    = (state == ST_RESP) && win_d;
        if_rdata   = if_rdata_q;
        d_rdata    = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and random scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, d_ready, mem_read, mem_write;

    logic        if_req4, d_req4, d_we4;
    logic [31:0] if_addr4, d_addr4, d_wdata4;
    logic [31:0] if_rdata4, d_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
    logic        if_ready4, d_ready4, mem_read4, mem_write4;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .if_req(if_req4), .if_addr(if_addr4), .if_rdata(if_rdata4), .if_ready(if_ready4),
        .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
        .d_rdata(d_rdata4), .d_ready(d_ready4),
        .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_read(mem_read4),
        .mem_write(mem_write4), .mem_rdata(mem_rdata4)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 16) ? 32'h2408_0005 : (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    // Memory contents are stored XORed with init_val so the zero-initialised array reads back init_val.
    bit   [31:0] mem_store [256];
    logic [7:0]  rd_age = 8'd0;
    logic [7:0]  rd_idx = 8'd0;
    logic [7:0]  age4   = 8'd0;

    always @(posedge clk) begin
        if (mem_write) mem_store[mem_addr[9:2]] <= mem_wdata ^ init_val(int'(mem_addr[9:2]));
        if (mem_read) begin
            rd_age <= 8'd1;
            rd_idx <= mem_addr[9:2];
        end else if (rd_age != 8'd0) begin
            rd_age <= rd_age + 8'd1;
        end
        if (mem_read4) age4 <= 8'd1;
        else if (age4 != 8'd0) age4 <= age4 + 8'd1;
    end

    assign mem_rdata  = (rd_age == 8'd1) ? (mem_store[rd_idx] ^ init_val(int'(rd_idx)))
                                         : (32'hBAD0_0000 | {24'h0, rd_age});
    assign mem_rdata4 = (age4 == 8'd4) ? 32'h1234_5678 : (32'hBAD1_0000 | {24'h0, age4});

    logic [31:0] ref_mem [256];
    logic [31:0] if_q [$];
    logic [31:0] d_q [$];
    logic [31:0] exp_if, exp_d;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_if = '0;
        exp_d = '0;
    endtask

    task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat, input string tag);
        int n, strobes, strobe_cyc;
        bit done, s_wr;
        logic [31:0] s_addr, s_wdata, exp;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
            if (we) ref_mem[addr[9:2]] = wdata;
            else exp_d = ref_mem[addr[9:2]];
            d_q.push_back(exp_d);
        end else begin
            if_req = 1'b1; if_addr = addr;
            exp_if = ref_mem[addr[9:2]];
            if_q.push_back(exp_if);
        end
        n = 0; strobes = 0; strobe_cyc = 0; done = 1'b0;
        s_wr = 1'b0; s_addr = '0; s_wdata = '0;
        while (!done && n < lat + 4) begin
            tick();
            n++;
            if (mem_read || mem_write) begin
                strobes++;
                strobe_cyc = n;
                s_wr = mem_write;
                s_addr = mem_addr;
                s_wdata = mem_wdata;
            end
            if (is_d ? d_ready : if_ready) done = 1'b1;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_strobe_count"}, strobes, 1);
        chk({tag, "_strobe_cycle"}, strobe_cyc, 1);
        chk({tag, "_strobe_kind"}, s_wr, we);
        chk({tag, "_mem_addr"}, s_addr, addr);
        if (we) chk({tag, "_mem_wdata"}, s_wdata, wdata);
        chk({tag, "_other_ready"}, is_d ? if_ready : d_ready, 1'b0);
        exp = is_d ? d_q.pop_front() : if_q.pop_front();
        chk({tag, "_rdata"}, is_d ? d_rdata : if_rdata, exp);
        if_req = 1'b0;
        d_req = 1'b0;
        tick();
        chk({tag, "_ready_pulse"}, {if_ready, d_ready}, 2'b00);
        chk({tag, "_rdata_held"}, is_d ? d_rdata : if_rdata, exp);
    endtask

    task automatic run_pair(input logic [31:0] ia, input logic [31:0] da,
                            input bit exp_d_first, input string tag);
        int n, first;
        bit got_if, got_d;
        if_req = 1'b1; if_addr = ia;
        exp_if = ref_mem[ia[9:2]];
        if_q.push_back(exp_if);
        d_req = 1'b1; d_we = 1'b0; d_addr = da;
        exp_d = ref_mem[da[9:2]];
        d_q.push_back(exp_d);
        n = 0; first = -1; got_if = 1'b0; got_d = 1'b0;
        while (!(got_if && got_d) && n < 20) begin
            tick();
            n++;
            if (if_ready && !got_if) begin
                chk({tag, "_one_ready"}, d_ready, 1'b0);
                chk({tag, "_if_rdata"}, if_rdata, if_q.pop_front());
                if (first < 0) first = 0;
                got_if = 1'b1;
                if_req = 1'b0;
            end
            if (d_ready && !got_d) begin
                chk({tag, "_d_rdata"}, d_rdata, d_q.pop_front());
                if (first < 0) first = 1;
                got_d = 1'b1;
                d_req = 1'b0;
            end
        end
        chk({tag, "_both_served"}, {got_if, got_d}, 2'b11);
        chk({tag, "_order"}, first, exp_d_first ? 1 : 0);
        if_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    initial begin
        int n, strobes4;
        bit done, if_busy, d_busy, prev_strobe, allow_new;
        int if_wait, d_wait, pend, n_if_done, n_d_done;
        logic [31:0] a;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        if_req4 = 1'b0; d_req4 = 1'b0; d_we4 = 1'b0;
        if_addr4 = '0; d_addr4 = '0; d_wdata4 = '0;
        do_reset();

        chk("reset_strobes", {mem_read, mem_write, if_ready, d_ready}, 4'b0000);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        chk("reset_rdata", {if_rdata, d_rdata}, 64'h0);
        chk("reset_dut4_outputs", {mem_read4, mem_write4, if_ready4, d_ready4, mem_addr4}, 36'h0);

        // Test 1: IF read at 0x40
        run_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 3, "t1_if_read");
        chk("t1_if_rdata_value", if_rdata, 32'h2408_0005);

        // Test 2: D read then D write; the write leaves d_rdata untouched
        run_txn(1'b1, 1'b0, 32'h0000_0180, 32'h0, 3, "t2_d_read");
        run_txn(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2, "t2_d_write");
        chk("t2_d_rdata_unchanged", d_rdata, ref_mem[8'h60]);
        run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3, "t2_readback");
        chk("t2_readback_value", d_rdata, 32'hDEAD_BEEF);

        // Test 3: simultaneous requests alternate
        do_reset();
        run_pair(32'h0000_0020, 32'h0000_01C0, 1'b0, "t3_pair_a");
        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 3, "t3_if_solo");
        run_pair(32'h0000_0024, 32'h0000_01C4, 1'b1, "t3_pair_b");

        // Test 4: RD_LAT=4 instance, address change after grant is ignored
        d_req4 = 1'b1; d_we4 = 1'b0; d_addr4 = 32'h0000_0200;
        tick();
        chk("t4_strobe", {mem_read4, mem_write4, mem_addr4}, {2'b10, 32'h0000_0200});
        tick();
        n = 2;
        d_addr4 = 32'h0000_0300;
        chk("t4_wait_addr_c2", mem_addr4, 32'h0000_0200);
        done = 1'b0;
        strobes4 = 0;
        while (!done && n < 12) begin
            tick();
            n++;
            if (n == 3) chk("t4_wait_addr_c3", mem_addr4, 32'h0000_0200);
            if (mem_read4 || mem_write4) strobes4++;
            if (d_ready4) done = 1'b1;
        end
        chk("t4_latency", n, 6);
        chk("t4_extra_strobes", strobes4, 0);
        chk("t4_d_rdata", d_rdata4, 32'h1234_5678);
        d_req4 = 1'b0;

        // Test 5: reset during WAIT aborts without a ready pulse
        if_req = 1'b1; if_addr = 32'h0000_0080;
        tick();
        chk("t5_strobe", mem_read, 1'b1);
        tick();
        rst = 1'b1;
        if_req = 1'b0;
        tick();
        chk("t5_flags_zero", {mem_read, mem_write, if_ready, d_ready}, 4'b0000);
        chk("t5_addr_data_zero", {mem_addr, mem_wdata}, 64'h0);
        chk("t5_rdata_cleared", {if_rdata, d_rdata}, 64'h0);
        rst = 1'b0;
        exp_if = '0;
        exp_d = '0;
        tick();
        chk("t5_no_late_ready", {if_ready, d_ready}, 2'b00);
        run_txn(1'b0, 1'b0, 32'h0000_0084, 32'h0, 3, "t5_recover");

        // Test 6: random dual-port traffic against the reference memory
        if_busy = 1'b0; d_busy = 1'b0; prev_strobe = 1'b0;
        if_wait = 0; d_wait = 0; pend = 0; n_if_done = 0; n_d_done = 0;
        for (int c = 0; c < 500; c++) begin
            allow_new = (c < 400);
            if (!allow_new && !if_busy && !d_busy) break;
            if (allow_new && !if_busy && $urandom_range(3) != 0) begin
                a = 32'($urandom_range(63)) * 32'd4;
                if_req = 1'b1; if_addr = a;
                if_q.push_back(ref_mem[a[9:2]]);
                if_busy = 1'b1; if_wait = 0;
            end
            if (allow_new && !d_busy && $urandom_range(3) != 0) begin
                d_we = 1'($urandom_range(1));
                d_req = 1'b1;
                if (d_we) begin
                    a = 32'h100 + 32'($urandom_range(63)) * 32'd4;
                    d_wdata = $urandom;
                    ref_mem[a[9:2]] = d_wdata;
                end else begin
                    a = 32'($urandom_range(127)) * 32'd4;
                    exp_d = ref_mem[a[9:2]];
                end
                d_addr = a;
                d_q.push_back(exp_d);
                d_busy = 1'b1; d_wait = 0;
            end
            tick();
            if (mem_read || mem_write) begin
                chk("rnd_strobe_excl", mem_read & mem_write, 1'b0);
                chk("rnd_strobe_single", prev_strobe, 1'b0);
                pend++;
            end
            prev_strobe = mem_read | mem_write;
            if (if_ready) begin
                chk("rnd_if_owner", if_busy, 1'b1);
                chk("rnd_one_ready", d_ready, 1'b0);
                chk("rnd_if_strobes", pend, 1);
                chk("rnd_if_wait", if_wait <= 12, 1'b1);
                pend = 0;
                if (if_busy) chk("rnd_if_rdata", if_rdata, if_q.pop_front());
                if_req = 1'b0; if_busy = 1'b0; n_if_done++;
            end else if (if_busy) begin
                if_wait++;
                if (if_wait > 12) begin
                    chk("rnd_if_starve", if_wait, 0);
                    void'(if_q.pop_front());
                    if_req = 1'b0; if_busy = 1'b0;
                end
            end
            if (d_ready) begin
                chk("rnd_d_owner", d_busy, 1'b1);
                chk("rnd_d_strobes", pend, 1);
                chk("rnd_d_wait", d_wait <= 12, 1'b1);
                pend = 0;
                if (d_busy) chk("rnd_d_rdata", d_rdata, d_q.pop_front());
                d_req = 1'b0; d_busy = 1'b0; n_d_done++;
            end else if (d_busy) begin
                d_wait++;
                if (d_wait > 12) begin
                    chk("rnd_d_starve", d_wait, 0);
                    void'(d_q.pop_front());
                    d_req = 1'b0; d_busy = 1'b0;
                end
            end
        end
        chk("rnd_drained", {if_busy, d_busy}, 2'b00);
        chk("rnd_queues_empty", if_q.size() + d_q.size(), 0);
        chk("rnd_if_progress", n_if_done > 40, 1'b1);
        chk("rnd_d_progress", n_d_done > 40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
